// File: rtl/estagio_busca_pkg.sv
// Shared types and defaults for the instruction-fetch stage.
package estagio_busca_pkg;

    localparam int XLEN = 32;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ     = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/if_id_latch.sv
// One instruction slot (valid, pc, instr, pc+4) with flush > hold > load priority.
// Used both as the IF/ID pipeline register and as the fetch skid buffer.
module if_id_latch #(
    parameter int           W   = 32,
    parameter logic [W-1:0] NOP = 'h13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         hold,
    input  logic         load,
    input  logic [W-1:0] in_pc,
    input  logic [W-1:0] in_instr,
    output logic         valid,
    output logic [W-1:0] pc,
    output logic [W-1:0] instr,
    output logic [W-1:0] pc_plus4
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            instr    <= NOP;
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (flush) begin
            valid <= 1'b0;
            instr <= NOP;
        end else if (!(hold && valid)) begin
            if (load) begin
                valid    <= 1'b1;
                pc       <= in_pc;
                instr    <= in_instr;
                pc_plus4 <= in_pc + W'(4);
            end else begin
                // Slot consumed with nothing behind it: present a bubble, keep pc fields.
                valid <= 1'b0;
                instr <= NOP;
            end
        end
    end

endmodule

// File: rtl/estagio_busca.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time,
// and fills the IF/ID register, parking a response in a skid slot while ID stalls.
module estagio_busca #(
    parameter int              XLEN      = estagio_busca_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = estagio_busca_pkg::RESET_PC,
    parameter logic [XLEN-1:0] INSTR_NOP = estagio_busca_pkg::INSTR_NOP
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            stall_id,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc_plus4
);

    import estagio_busca_pkg::*;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            slot_free;
    logic            wait_load;
    logic            wait_skid;
    logic            hold_drain;
    logic            load_if_id;
    logic [XLEN-1:0] load_pc;
    logic [XLEN-1:0] load_instr;

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc_plus4;

    // Instructions are word aligned; the low two bits of any PC are dropped.
    assign target    = redirect_pc & ALIGN_MASK;
    assign imem_addr = pc & ALIGN_MASK;

    assign imem_req_valid = (state == REQ) && !reset;
    assign accept         = imem_req_valid && imem_req_ready;
    assign slot_free      = !if_id_valid || !stall_id;

    assign wait_load  = (state == WAIT) && imem_resp_valid && slot_free && !redirect_valid;
    assign wait_skid  = (state == WAIT) && imem_resp_valid && !slot_free && !redirect_valid;
    assign hold_drain = (state == HOLD) && skid_valid && !stall_id && !redirect_valid;
    assign load_if_id = wait_load || hold_drain;

    assign load_pc    = hold_drain ? skid_pc : imem_addr;
    assign load_instr = hold_drain ? skid_instr : imem_resp_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= REQ;
            pc    <= RESET_PC;
        end else begin
            case (state)
                REQ: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        // A request accepted alongside a redirect is wrong-path; drain it.
                        state <= accept ? DISCARD : REQ;
                    end else if (accept) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= imem_resp_valid ? REQ : DISCARD;
                    end else if (imem_resp_valid) begin
                        if (slot_free) begin
                            pc    <= imem_addr + XLEN'(4);
                            state <= REQ;
                        end else begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (hold_drain) begin
                        pc    <= skid_pc_plus4;
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        pc <= target;
                    end
                    if (imem_resp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

    if_id_latch #(
        .W   (XLEN),
        .NOP (INSTR_NOP)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .hold     (stall_id),
        .load     (wait_skid),
        .in_pc    (imem_addr),
        .in_instr (imem_resp_data),
        .valid    (skid_valid),
        .pc       (skid_pc),
        .instr    (skid_instr),
        .pc_plus4 (skid_pc_plus4)
    );

    if_id_latch #(
        .W   (XLEN),
        .NOP (INSTR_NOP)
    ) u_if_id (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .hold     (stall_id),
        .load     (load_if_id),
        .in_pc    (load_pc),
        .in_instr (load_instr),
        .valid    (if_id_valid),
        .pc       (if_id_pc),
        .instr    (if_id_instr),
        .pc_plus4 (if_id_pc_plus4)
    );

endmodule
